scan_seq38: RTL
===============

SCAN_SEQ38 -- requirements
Module: scan_seq38

Interface
REQ-001 SHALL have parameter DWELL_W, default 8: width of the per-slot dwell count.
REQ-002 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1: request a scan (sampled in IDLE only).
REQ-005 SHALL have port stop, input, 1: synchronous abort of a scan.
REQ-006 SHALL have port mode, input, 1: 0 = continuous, 1 = single sweep.
REQ-007 SHALL have port dir, input, 1: 0 = ascending codes, 1 = descending.
REQ-008 SHALL have port mask, input, 8: bit i=1 enables code i.
REQ-009 SHALL have port dwell, input, DWELL_W: cycles per slot; 0 is treated as 1.
REQ-010 SHALL have port code, output, 3: select code, feeding a 3-to-8 decoder select input.
REQ-011 SHALL have port en, output, 1: code valid; gates the decoder outputs.
REQ-012 SHALL have port step, output, 1: one-cycle pulse when code changes within a scan.
REQ-013 SHALL have port done, output, 1: one-cycle pulse at sweep completion or wrap.
REQ-014 SHALL have port busy, output, 1: high while in SCAN.

Function
REQ-015 SHALL implement states IDLE and SCAN.
REQ-016 In IDLE with start=1, stop=0 and mask!=0, SHALL capture mode, dir, mask and dwell into shadow registers and enter SCAN next cycle.
REQ-017 On SCAN entry, SHALL set code to the first enabled code (lowest if dir=0, highest if dir=1), with en=1, busy=1 and step=0.
REQ-018 Each slot SHALL last max(dwell,1) cycles, counted by a down-counter loaded with max(dwell,1)-1.
REQ-019 When the slot ends and another enabled code exists, SHALL advance code to the next enabled code in dir (skipping masked codes) and pulse step=1 in the first cycle of the new code.
REQ-020 Wrap rule: after code 7 (up) or code 0 (down), the search SHALL continue from 0 or 7 respectively.
REQ-021 When the slot of the last enabled code in sweep order ends, mode=1 SHALL return to IDLE with en=0, busy=0 and done=1 in the same cycle.
REQ-022 When the slot of the last enabled code in sweep order ends, mode=0 SHALL wrap to the first enabled code with step=1 and done=1 together.
REQ-023 With a single enabled code and mode=0, code SHALL stay constant while step and done pulse every slot.
REQ-024 stop=1 in SCAN SHALL force IDLE next cycle with en=0, busy=0 and no done; code SHALL hold its last value.
REQ-025 start while in SCAN SHALL be ignored.
REQ-026 start=1 with stop=1 in IDLE SHALL be ignored.
REQ-027 start with mask=0 SHALL be ignored, and the block SHALL remain in IDLE.
REQ-028 Input changes to mode, dir, mask or dwell during SCAN SHALL have no effect until the next start.
REQ-029 step and done SHALL never be high in IDLE except the done cycle of REQ-021.

Reset
REQ-030 rst_n=0 SHALL asynchronously force IDLE with code=0, en=0, step=0, done=0, busy=0, and clear the shadow registers and dwell counter.
REQ-031 Reset asserted mid-scan SHALL abort the scan without a done pulse; after release the block SHALL wait for a new start.

Structure
REQ-032 Package scan_pkg SHALL hold the state enum (IDLE, SCAN) and the DWELL_W default constant.
REQ-033 Sub-module scan_next SHALL be purely combinational, taking code, dir and mask and returning the next enabled code plus a wrapped flag.
REQ-034 The top level SHALL contain the FSM, the dwell counter and the registered outputs; all outputs SHALL be registered.

Verification
REQ-035 mask=8'hFF, dwell=2, mode=1, dir=0, start -> code 0..7 at 2 cycles each, step on each change, done with en falling after 16 cycles of en.
REQ-036 mask=8'b1010_0100, dwell=1, mode=0, dir=1 -> code 7,5,2,7,5,2...; done on every 2->7 transition.
REQ-037 dwell=0, mask=8'h01, mode=0 -> code stays 0; step and done high every cycle after the first SCAN cycle.
REQ-038 Stop in mid-slot at code 3 -> en=0 and busy=0 the next cycle, code holds 3, no done; subsequent start with mask=0 -> remains IDLE.
REQ-039 Change mask and dir mid-scan -> sequence unchanged; rst_n low mid-scan -> outputs zero immediately (asynchronous), no done.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and constants for the scan_seq38 code sequencer.
//   state_e     : sequencer states (IDLE, SCAN)
//   DWELL_W_DEF : default width of the per-slot dwell count
//   CODE_W      : width of the decoder select code
//   NUM_CODES   : number of selectable codes (one mask bit each)
`timescale 1ns/1ps
package scan_pkg;

  localparam int unsigned DWELL_W_DEF = 8;
  localparam int unsigned CODE_W      = 3;
  localparam int unsigned NUM_CODES   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/scan_seq38_if.sv
// Control/status bundle of the scan sequencer.
//   start, stop, mode, dir, mask, dwell : scan request and configuration
//   code, en, step, done, busy          : decoder select and scan status
// Modports: master drives requests, slave (the sequencer) drives status.
`timescale 1ns/1ps
interface scan_seq38_if #(
  parameter int unsigned DWELL_W = scan_pkg::DWELL_W_DEF
);

  logic                           start;
  logic                           stop;
  logic                           mode;
  logic                           dir;
  logic [scan_pkg::NUM_CODES-1:0] mask;
  logic [DWELL_W-1:0]             dwell;
  logic [scan_pkg::CODE_W-1:0]    code;
  logic                           en;
  logic                           step;
  logic                           done;
  logic                           busy;

  modport master (
    output start, stop, mode, dir, mask, dwell,
    input  code, en, step, done, busy
  );

  modport slave (
    input  start, stop, mode, dir, mask, dwell,
    output code, en, step, done, busy
  );

endinterface

// File: rtl/scan_next.sv
// Combinational next-enabled-code search.
//   code_i    : current code
//   dir_i     : 0 = search upward, 1 = search downward
//   mask_i    : enabled codes
//   next_o    : nearest enabled code after code_i in dir_i order (wrapping)
//   wrapped_o : search crossed the 7->0 (up) or 0->7 (down) boundary
// The current code itself is examined last, so a single enabled code maps
// onto itself with wrapped_o set.
`timescale 1ns/1ps
module scan_next
  import scan_pkg::*;
(
  input  logic [CODE_W-1:0]    code_i,
  input  logic                 dir_i,
  input  logic [NUM_CODES-1:0] mask_i,
  output logic [CODE_W-1:0]    next_o,
  output logic                 wrapped_o
);

  logic              found;
  logic [CODE_W-1:0] cand;

  // Walk distances 1..8 from code_i; keep the first enabled candidate.
  always_comb begin
    next_o    = code_i;
    wrapped_o = 1'b0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_CODES; k++) begin
      if (dir_i) begin
        cand = code_i - CODE_W'(k);
      end else begin
        cand = code_i + CODE_W'(k);
      end
      if (!found && mask_i[cand]) begin
        found  = 1'b1;
        next_o = cand;
        if (dir_i) begin
          wrapped_o = (4'(k) > {1'b0, code_i});
        end else begin
          wrapped_o = (({1'b0, code_i} + 4'(k)) > 4'd7);
        end
      end
    end
  end

endmodule

// File: rtl/scan_seq38.sv
// Scan sequencer driving the select/enable of a 3-to-8 decoder.
// Steps through the enabled codes of a captured mask in the captured
// direction, dwelling max(dwell,1) cycles per code; single-sweep or
// continuous.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : scan_seq38_if slave (request/config in, code/status out)
`timescale 1ns/1ps
module scan_seq38
  import scan_pkg::*;
#(
  parameter int unsigned DWELL_W = DWELL_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  scan_seq38_if.slave  bus
);

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic                 dir_q, dir_d;
  logic [NUM_CODES-1:0] mask_q, mask_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic                 en_q, en_d;
  logic                 step_q, step_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic [CODE_W-1:0]    nx_cur_c;
  logic                 nx_dir_c;
  logic [NUM_CODES-1:0] nx_mask_c;
  logic [CODE_W-1:0]    nx_code_c;
  logic                 nx_wrap_c;

  // Counter reload value: a dwell of 0 behaves as 1.
  function automatic logic [DWELL_W-1:0] slot_load(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - DWELL_W'(1);
  endfunction

  // In IDLE, search from just before the sweep start so the result is the
  // first enabled code; in SCAN, search from the current code.
  always_comb begin
    if (state_q == IDLE) begin
      nx_cur_c  = bus.dir ? '0 : '1;
      nx_dir_c  = bus.dir;
      nx_mask_c = bus.mask;
    end else begin
      nx_cur_c  = code_q;
      nx_dir_c  = dir_q;
      nx_mask_c = mask_q;
    end
  end

  scan_next u_next (
    .code_i    (nx_cur_c),
    .dir_i     (nx_dir_c),
    .mask_i    (nx_mask_c),
    .next_o    (nx_code_c),
    .wrapped_o (nx_wrap_c)
  );

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    en_d    = en_q;
    busy_d  = busy_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop && (bus.mask != '0)) begin
          state_d = SCAN;
          mode_d  = bus.mode;
          dir_d   = bus.dir;
          mask_d  = bus.mask;
          dwell_d = bus.dwell;
          cnt_d   = slot_load(bus.dwell);
          code_d  = nx_code_c;
          en_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        if (bus.stop) begin
          // Abort: code holds its last value, no done.
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (nx_wrap_c && mode_q) begin
          // Last slot of a single sweep.
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          // Wrapping back to the first code marks the end of a sweep.
          code_d = nx_code_c;
          step_d = 1'b1;
          done_d = nx_wrap_c;
          cnt_d  = slot_load(dwell_q);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, shadow configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      dir_q   <= 1'b0;
      mask_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      en_q    <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      en_q    <= en_d;
      step_q  <= step_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.code = code_q;
  assign bus.en   = en_q;
  assign bus.step = step_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

endmodule
